// File: rtl/display_pkg.sv
// Shared types and default sizing for the display control block.
package display_pkg;

    // FSM states: default-image pass, idle, box pass, shift wait.
    typedef enum logic [3:0] {
        D_ADDR, D_LOAD, D_WRITE, D_PLOT,
        IDLE,
        B_ADDR, B_SUM, B_LOADX, B_LOADY, B_WRITE, B_PLOT,
        WAIT, SHIFT
    } state_t;

    localparam int unsigned DEF_GRID_PIXELS   = 43200;    // 240*180 grid
    localparam int unsigned DEF_NUM_BOXES     = 3;
    localparam int unsigned DEF_BOX_PIXELS    = 256;
    localparam int unsigned DEF_SHIFT_PERIOD  = 12500000; // 4 Hz at 50 MHz

    localparam int unsigned CYC_PER_DEF_PIXEL = 4;
    localparam int unsigned CYC_PER_BOX_PIXEL = 6;

    // One bit per datapath strobe, registered as a group.
    typedef struct packed {
        logic shift_song;
        logic load_start;
        logic load_x;
        logic load_y;
        logic load_default;
        logic write_screen;
        logic write_default;
        logic plot;
    } strobe_t;

    // Strobe pattern the datapath must see while the FSM sits in state s.
    // The start address is only reloaded on the first pixel of a box.
    function automatic strobe_t strobes_for(input state_t s, input logic first_pixel);
        strobe_t st;
        st = '0;
        case (s)
            D_LOAD:  st.load_default  = 1'b1;
            D_WRITE: begin
                st.write_screen  = 1'b1;
                st.write_default = 1'b1;
            end
            D_PLOT:  st.plot          = 1'b1;
            B_ADDR:  st.load_start    = first_pixel;
            B_LOADX: st.load_x        = 1'b1;
            B_LOADY: st.load_y        = 1'b1;
            B_WRITE: st.write_screen  = 1'b1;
            B_PLOT:  st.plot          = 1'b1;
            SHIFT:   st.shift_song    = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Idle-period timer: counts PERIOD cycles while enabled, one-cycle tick on the last.
module shift_tick_gen
    import display_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_SHIFT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int          W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Counter is held at zero whenever disabled so each WAIT starts fresh.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (!i_en || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/display_control.sv
// Control FSM for the display datapath: default image once, then box redraw loop.
module display_control
    import display_pkg::*;
#(
    parameter int unsigned GRID_PIXELS  = DEF_GRID_PIXELS,
    parameter int unsigned NUM_BOXES    = DEF_NUM_BOXES,
    parameter int unsigned BOX_PIXELS   = DEF_BOX_PIXELS,
    parameter int unsigned SHIFT_PERIOD = DEF_SHIFT_PERIOD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    output logic        shiftSong,
    output logic        loadStartAddress,
    output logic        loadX,
    output logic        loadY,
    output logic        loadDefault,
    output logic        writeToScreen,
    output logic        writeDefault,
    output logic [15:0] gridCounter,
    output logic [3:0]  boxCounter,
    output logic [15:0] pixelCount,
    output logic        plot,
    output logic        defaultDone,
    output logic        frameDone
);

    localparam logic [15:0] GRID_LAST = 16'(GRID_PIXELS - 1);
    localparam logic [3:0]  BOX_LAST  = 4'(NUM_BOXES - 1);
    localparam logic [15:0] PIX_LAST  = 16'(BOX_PIXELS - 1);

    state_t      r_state, w_next;
    strobe_t     r_strb, w_strb;
    logic [15:0] r_grid, w_grid;
    logic [3:0]  r_box, w_box;
    logic [15:0] r_pix, w_pix;
    logic        r_def_done, w_def_done;
    logic        r_frame, w_frame;
    logic        r_go_pend, w_go_pend;
    logic        w_tick;

    shift_tick_gen #(
        .PERIOD (SHIFT_PERIOD)
    ) u_tick (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_en    (r_state == WAIT),
        .o_tick  (w_tick)
    );

    // State register; reset aborts any pass and restarts the default image.
    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= D_ADDR;
        else
            r_state <= w_next;
    end

    // Next state, next counter values and next strobes.
    always_comb begin
        w_next     = r_state;
        w_grid     = r_grid;
        w_box      = r_box;
        w_pix      = r_pix;
        w_def_done = r_def_done;
        w_frame    = 1'b0;
        w_go_pend  = r_go_pend | go;

        case (r_state)
            D_ADDR:  w_next = D_LOAD;
            D_LOAD:  w_next = D_WRITE;
            D_WRITE: w_next = D_PLOT;
            D_PLOT: begin
                if (r_grid == GRID_LAST) begin
                    w_next     = IDLE;
                    w_grid     = '0;
                    w_def_done = 1'b1;
                end else begin
                    w_next = D_ADDR;
                    w_grid = r_grid + 16'd1;
                end
            end
            IDLE: begin
                // go seen during the default pass is still honoured here
                if (go || r_go_pend) begin
                    w_next    = B_ADDR;
                    w_go_pend = 1'b0;
                end
            end
            B_ADDR:  w_next = B_SUM;
            B_SUM:   w_next = B_LOADX;
            B_LOADX: w_next = B_LOADY;
            B_LOADY: w_next = B_WRITE;
            B_WRITE: w_next = B_PLOT;
            B_PLOT: begin
                w_next = B_ADDR;
                if (r_pix < PIX_LAST) begin
                    w_pix = r_pix + 16'd1;
                end else begin
                    w_pix = '0;
                    if (r_box < BOX_LAST) begin
                        w_box = r_box + 4'd1;
                    end else begin
                        w_box   = '0;
                        w_frame = 1'b1;
                        w_next  = WAIT;
                    end
                end
            end
            WAIT:    if (w_tick) w_next = SHIFT;
            SHIFT:   w_next = B_ADDR;
            default: w_next = D_ADDR;
        endcase

        // Strobes are decoded from the state being entered so the registered
        // copy lines up with the cycle the FSM spends in that state.
        w_strb = strobes_for(w_next, (w_pix == '0));
    end

    // Output and counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_strb     <= '0;
            r_grid     <= '0;
            r_box      <= '0;
            r_pix      <= '0;
            r_def_done <= 1'b0;
            r_frame    <= 1'b0;
            r_go_pend  <= 1'b0;
        end else begin
            r_strb     <= w_strb;
            r_grid     <= w_grid;
            r_box      <= w_box;
            r_pix      <= w_pix;
            r_def_done <= w_def_done;
            r_frame    <= w_frame;
            r_go_pend  <= w_go_pend;
        end
    end

    assign shiftSong        = r_strb.shift_song;
    assign loadStartAddress = r_strb.load_start;
    assign loadX            = r_strb.load_x;
    assign loadY            = r_strb.load_y;
    assign loadDefault      = r_strb.load_default;
    assign writeToScreen    = r_strb.write_screen;
    assign writeDefault     = r_strb.write_default;
    assign plot             = r_strb.plot;
    assign gridCounter      = r_grid;
    assign boxCounter       = r_box;
    assign pixelCount       = r_pix;
    assign defaultDone      = r_def_done;
    assign frameDone        = r_frame;

endmodule

// File: tb/tb_display_control.sv
// Directed bench for display_control with a cycle-schedule reference model.
module tb_display_control;
    import display_pkg::*;

    localparam int G      = 4;
    localparam int NB     = 3;
    localparam int BP     = 2;
    localparam int SP     = 10;
    localparam int DEFLEN = G * CYC_PER_DEF_PIXEL;      // 16
    localparam int PASS   = NB * BP * CYC_PER_BOX_PIXEL; // 36
    localparam int LOOP   = PASS + SP + 1;               // 47

    logic        clock, reset, go;
    logic        shiftSong, loadStartAddress, loadX, loadY, loadDefault;
    logic        writeToScreen, writeDefault, plot, defaultDone, frameDone;
    logic [15:0] gridCounter, pixelCount;
    logic [3:0]  boxCounter;

    int n_chk  = 0;
    int n_fail = 0;

    display_control #(
        .GRID_PIXELS (G), .NUM_BOXES (NB), .BOX_PIXELS (BP), .SHIFT_PERIOD (SP)
    ) dut (
        .clock (clock), .reset (reset), .go (go),
        .shiftSong (shiftSong), .loadStartAddress (loadStartAddress),
        .loadX (loadX), .loadY (loadY), .loadDefault (loadDefault),
        .writeToScreen (writeToScreen), .writeDefault (writeDefault),
        .gridCounter (gridCounter), .boxCounter (boxCounter),
        .pixelCount (pixelCount), .plot (plot),
        .defaultDone (defaultDone), .frameDone (frameDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase (0 default, 1 idle, 2 loop) and cycle offset in it.
    int mphase = 0, mt = 0, cyc = 0;
    bit mrst = 1'b1, mpend = 1'b0, started = 1'b0, first_run = 1'b1;

    always @(posedge clock) begin
        started <= 1'b1;
        if (!reset) begin
            mrst <= 1'b1; mphase <= 0; mt <= 0; mpend <= 1'b0; cyc <= 1;
        end else begin
            mrst <= 1'b0;
            cyc  <= cyc + 1;
            case (mphase)
                0: begin
                    mpend <= mpend | go;
                    if (mt == DEFLEN - 1) begin mphase <= 1; mt <= 0; end
                    else mt <= mt + 1;
                end
                1: if (go || mpend) begin mphase <= 2; mt <= 0; mpend <= 1'b0; end
                default: mt <= (mt + 1) % LOOP;
            endcase
        end
    end

    // Expected outputs as {strobes(8), defaultDone, frameDone, box, grid, pix}.
    function automatic logic [45:0] model_out(input bit rst, input int ph, input int t);
        logic [7:0] s;   // ss lsa lx ly ld wts wd pl
        logic dd, fd;
        int box, grid, pix, k, sub;
        s = '0; dd = 0; fd = 0; box = 0; grid = 0; pix = 0;
        if (!rst) begin
            if (ph == 0) begin
                grid = t / 4; sub = t % 4;
                if (sub == 1) s[3] = 1;
                if (sub == 2) begin s[2] = 1; s[1] = 1; end
                if (sub == 3) s[0] = 1;
            end else if (ph == 1) begin
                dd = 1;
            end else begin
                dd = 1;
                if (t < PASS) begin
                    k = t / 6; sub = t % 6; box = k / BP; pix = k % BP;
                    if (sub == 0) s[6] = (pix == 0);
                    if (sub == 2) s[5] = 1;
                    if (sub == 3) s[4] = 1;
                    if (sub == 4) s[2] = 1;
                    if (sub == 5) s[0] = 1;
                end else if (t < PASS + SP) begin
                    fd = (t == PASS);
                end else begin
                    s[7] = 1;
                end
            end
        end
        return {s, dd, fd, 4'(box), 16'(grid), 16'(pix)};
    endfunction

    logic [45:0] act_v;
    assign act_v = {shiftSong, loadStartAddress, loadX, loadY, loadDefault,
                    writeToScreen, writeDefault, plot, defaultDone, frameDone,
                    boxCounter, gridCounter, pixelCount};

    // Per-cycle compare against the model, legality checks, and pinned literals.
    always @(negedge clock) begin
        if (started) begin
            int n;
            bit legal;
            chk("outputs", 64'(act_v), 64'(model_out(mrst, mphase, mt)));
            n = int'(shiftSong) + int'(loadStartAddress) + int'(loadX) + int'(loadY)
              + int'(loadDefault) + int'(writeToScreen) + int'(plot);
            legal = (n <= 1) && (!writeDefault || writeToScreen) &&
                    (gridCounter < G) && (boxCounter < NB) && (pixelCount < BP);
            chk("strobe_legal", 64'(legal), 64'd1);
            if (first_run && reset) begin
                case (cyc)
                    4:  begin chk("c4_plot", 64'(plot), 64'd1); chk("c4_grid", 64'(gridCounter), 64'd0); end
                    15: chk("c15_wts_wd", 64'({writeToScreen, writeDefault, gridCounter}), 64'h30003);
                    16: begin chk("c16_plot", 64'(plot), 64'd1); chk("c16_grid", 64'(gridCounter), 64'd3);
                              chk("c16_done", 64'(defaultDone), 64'd0); end
                    17: chk("c17_defaultDone", 64'(defaultDone), 64'd1);
                    18: chk("c18_lsa", 64'(loadStartAddress), 64'd1);
                    24: chk("c24_lsa", 64'({loadStartAddress, pixelCount}), 64'h00001);
                    41: chk("c41_plot_b1p1", 64'({plot, boxCounter, pixelCount}), 64'h110001);
                    54: chk("c54_frameDone", 64'(frameDone), 64'd1);
                    63: chk("c63_shift", 64'(shiftSong), 64'd0);
                    64: chk("c64_shift", 64'(shiftSong), 64'd1);
                    65: chk("c65_lsa_box0", 64'({loadStartAddress, boxCounter}), 64'h10);
                    default: ;
                endcase
            end
        end
    end

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected completion before t=%0t", $time);
        summary();
        $finish;
    end

    initial begin
        bit found;
        reset = 1'b0; go = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        // go pulse mid default pass must be remembered
        for (int i = 0; i < 20 && cyc != 5; i++) begin @(posedge clock); #1; end
        go = 1'b1;
        @(posedge clock); #1 go = 1'b0;
        // three full loops
        repeat (18 + 3 * LOOP) @(posedge clock);
        #1;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (boxCounter == 4'd1 && pixelCount == 16'd1) found = 1;
            else begin @(posedge clock); #1; end
        end
        chk("find_box1_pix1", 64'(found), 64'd1);
        first_run = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("mid_reset_zero", 64'(act_v), 64'd0);
        @(posedge clock); #1 reset = 1'b1;
        // default pass again, then idle without go
        repeat (DEFLEN + 20) @(posedge clock);
        #1;
        chk("idle_no_go", 64'({defaultDone, plot, loadStartAddress}), 64'h4);
        go = 1'b1;
        @(posedge clock); #1 go = 1'b0;
        repeat (LOOP + 10) @(posedge clock);
        #1;
        summary();
        $finish;
    end

endmodule
